// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with redirect, halt and misalignment trap handling
module pc_sequencer #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             Fetch_Valid,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             Misalign_Err,
    output logic [CNT_W-1:0] Redirect_Cnt,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        TRAP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             flush;

    // Target bits above the PC width are dropped on purpose; fold them here so they are visibly consumed.
    logic unused_brpc_hi;
    assign unused_brpc_hi = ^BrPC[31:PC_W];

    // State register; reset returns to BOOT with fetch address 0 and clears the counter and sticky flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    // Next-state and flush decode; in RUN the priority is Halt, then redirect, then stall, then advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        flush   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (Halt) begin
                    flush   = 1'b1;
                    state_d = HALTED;
                end else if (PcSel) begin
                    // A redirect wins over Stall; the wrong-path instructions must die either way.
                    flush = 1'b1;
                    if (BrPC[1:0] != 2'b00) begin
                        state_d = TRAP;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d = BrPC[PC_W-1:0];
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end else if (!Stall) begin
                    pc_d = pc_q + PC_W'(3'd4);
                end
            end
            default: begin
                // HALTED and TRAP hold everything until reset.
            end
        endcase
    end

    assign PC           = pc_q;
    assign Fetch_Valid  = (state_q == RUN);
    assign IF_Flush     = flush;
    assign ID_Flush     = flush;
    assign Misalign_Err = mis_q;
    assign Redirect_Cnt = cnt_q;
    assign State        = state_q;

endmodule
